// File: rtl/background_subtract_pkg.sv
// Shared definitions for the grayscale image stages: FSM states and default frame geometry.
package background_subtract_pkg;

  localparam int PIX_W         = 8;
  localparam int DEF_THRESHOLD = 50;
  localparam int DEF_WIDTH     = 720;
  localparam int DEF_HEIGHT    = 540;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/background_subtract_if.sv
// FIFO-side bundle of the background subtractor: two input FIFOs, one output FIFO, frame pulse.
interface background_subtract_if;
  import background_subtract_pkg::*;

  logic             bg_read_enable;
  logic [PIX_W-1:0] bg_din;
  logic             bg_fifo_empty;
  logic             fr_read_enable;
  logic [PIX_W-1:0] fr_din;
  logic             fr_fifo_empty;
  logic             write_enable;
  logic [PIX_W-1:0] data_out;
  logic             fifo_out_full;
  logic             frame_done;

  // master: the subtractor itself; slave: the surrounding FIFOs / environment
  modport master (
    output bg_read_enable, fr_read_enable, write_enable, data_out, frame_done,
    input  bg_din, bg_fifo_empty, fr_din, fr_fifo_empty, fifo_out_full
  );

  modport slave (
    input  bg_read_enable, fr_read_enable, write_enable, data_out, frame_done,
    output bg_din, bg_fifo_empty, fr_din, fr_fifo_empty, fifo_out_full
  );

endinterface

// File: rtl/background_subtract.sv
// Foreground mask generator: pops a background and a frame pixel together, thresholds their
// absolute difference and pushes 8'hFF/8'h00, pulsing frame_done after the last pixel of a frame.
module background_subtract
  import background_subtract_pkg::*;
#(
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HEIGHT    = DEF_HEIGHT
) (
  input  logic                  clk,
  input  logic                  reset,
  background_subtract_if.master bus
);

  localparam int                PIXELS   = WIDTH * HEIGHT;
  localparam int                CNT_W    = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam logic [CNT_W-1:0]  LAST_PIX = CNT_W'(PIXELS - 1);
  localparam logic [PIX_W-1:0]  THRESH   = PIX_W'(THRESHOLD);

  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  state_t           state, state_next;
  logic [PIX_W-1:0] bg_p0, fr_p0;
  logic [PIX_W-1:0] diff_p1;
  logic             hit_p1;
  logic [PIX_W-1:0] mask_p1;
  logic [CNT_W-1:0] pix_cnt;
  logic             frame_done_q;
  logic             rd_go, wr_go;

  always_ff @(posedge clk) begin
    if (reset) state <= S_READ;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_READ:  if (!bus.bg_fifo_empty && !bus.fr_fifo_empty) state_next = S_CALC;
      S_CALC:  state_next = S_WRITE;
      S_WRITE: if (!bus.fifo_out_full) state_next = S_READ;
      default: state_next = S_READ;
    endcase
  end

  // Enables are combinational from state and flags, gated off while reset is held
  always_comb begin
    rd_go = 1'b0;
    wr_go = 1'b0;
    if (!reset) begin
      rd_go = (state == S_READ) && !bus.bg_fifo_empty && !bus.fr_fifo_empty;
      wr_go = (state == S_WRITE) && !bus.fifo_out_full;
    end
  end

  always_comb begin
    diff_p1 = abs_diff(fr_p0, bg_p0);
    hit_p1  = (diff_p1 > THRESH);
  end

  // p0: pixel pair latched on the read; p1: mask registered in S_CALC; counter advances on writes
  always_ff @(posedge clk) begin
    if (reset) begin
      bg_p0        <= '0;
      fr_p0        <= '0;
      mask_p1      <= '0;
      pix_cnt      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (rd_go) begin
        bg_p0 <= bus.bg_din;
        fr_p0 <= bus.fr_din;
      end
      if (state == S_CALC) mask_p1 <= hit_p1 ? 8'hFF : 8'h00;
      if (wr_go) begin
        if (pix_cnt == LAST_PIX) begin
          pix_cnt      <= '0;
          frame_done_q <= 1'b1;
        end else begin
          pix_cnt <= pix_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.bg_read_enable = rd_go;
  assign bus.fr_read_enable = rd_go;
  assign bus.write_enable   = wr_go;
  assign bus.data_out       = wr_go ? mask_p1 : 8'h00;
  assign bus.frame_done     = frame_done_q;

endmodule

// File: tb/tb_background_subtract.sv
// Directed bench for background_subtract on a 4x2 frame: vector table plus stall, back-pressure and reset sequences.
module tb_background_subtract;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  background_subtract_if bus ();

  background_subtract #(
    .THRESHOLD(50),
    .WIDTH    (4),
    .HEIGHT   (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bg;
    logic [7:0] fr;
    logic [7:0] mask;
    logic       fd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered at the read-cycle sample point; walks S_CALC, S_WRITE and the cycle after the write
  task automatic finish_pixel(input logic [7:0] exp_mask, input logic exp_fd, input string tag);
    @(negedge clk);
    bus.bg_fifo_empty = 1'b1;
    bus.fr_fifo_empty = 1'b1;
    #1;
    check({tag, "_calc_we"}, int'(bus.write_enable), 0);
    @(negedge clk); #1;
    check({tag, "_we"}, int'(bus.write_enable), 1);
    check({tag, "_mask"}, int'(bus.data_out), int'(exp_mask));
    @(negedge clk); #1;
    check({tag, "_fd"}, int'(bus.frame_done), int'(exp_fd));
    check({tag, "_after_we"}, int'(bus.write_enable), 0);
  endtask

  task automatic run_pixel(input logic [7:0] bg, input logic [7:0] fr, input logic [7:0] exp_mask,
                           input logic exp_fd, input string tag);
    int waited;
    bus.bg_din        = bg;
    bus.fr_din        = fr;
    bus.bg_fifo_empty = 1'b0;
    bus.fr_fifo_empty = 1'b0;
    #1;
    waited = 0;
    while (!bus.bg_read_enable && waited < 8) begin
      @(negedge clk); #1;
      waited++;
    end
    check({tag, "_rd"}, int'({bus.bg_read_enable, bus.fr_read_enable}), 3);
    finish_pixel(exp_mask, exp_fd, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{8'd100, 8'd160, 8'hFF, 1'b0};
    vecs[1] = '{8'd200, 8'd150, 8'h00, 1'b0};
    vecs[2] = '{8'd0,   8'd255, 8'hFF, 1'b0};
    vecs[3] = '{8'd150, 8'd200, 8'h00, 1'b0};
    vecs[4] = '{8'd100, 8'd151, 8'hFF, 1'b0};
    vecs[5] = '{8'd77,  8'd77,  8'h00, 1'b0};
    vecs[6] = '{8'd255, 8'd0,   8'hFF, 1'b0};
    vecs[7] = '{8'd30,  8'd80,  8'h00, 1'b1};

    // Reset held with both FIFOs offering data: nothing may move
    bus.bg_din        = 8'd1;
    bus.fr_din        = 8'd200;
    bus.bg_fifo_empty = 1'b0;
    bus.fr_fifo_empty = 1'b0;
    bus.fifo_out_full = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_bg_re", int'(bus.bg_read_enable), 0);
    check("rst_fr_re", int'(bus.fr_read_enable), 0);
    check("rst_we", int'(bus.write_enable), 0);
    check("rst_dout", int'(bus.data_out), 0);
    check("rst_fd", int'(bus.frame_done), 0);
    bus.bg_fifo_empty = 1'b1;
    bus.fr_fifo_empty = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;

    // One full 4x2 frame; frame_done only after the 8th write
    for (int i = 0; i < 8; i++) run_pixel(vecs[i].bg, vecs[i].fr, vecs[i].mask, vecs[i].fd,
                                          $sformatf("vec%0d", i));

    // bg ready but fr empty for 10 cycles: no pops at all
    bus.bg_din        = 8'd10;
    bus.fr_din        = 8'd90;
    bus.bg_fifo_empty = 1'b0;
    bus.fr_fifo_empty = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check($sformatf("stall%0d_re", i), int'({bus.bg_read_enable, bus.fr_read_enable}), 0);
    end
    bus.fr_fifo_empty = 1'b0;
    #1;
    check("stall_pop", int'({bus.bg_read_enable, bus.fr_read_enable}), 3);
    finish_pixel(8'hFF, 1'b0, "stall");

    // Output FIFO full for 5 cycles in S_WRITE: mask held, single write once it drains
    bus.bg_din        = 8'd60;
    bus.fr_din        = 8'd5;
    bus.bg_fifo_empty = 1'b0;
    bus.fr_fifo_empty = 1'b0;
    #1;
    check("bp_rd", int'({bus.bg_read_enable, bus.fr_read_enable}), 3);
    @(negedge clk);
    bus.bg_fifo_empty = 1'b1;
    bus.fr_fifo_empty = 1'b1;
    bus.fifo_out_full = 1'b1;
    #1;
    check("bp_calc_we", int'(bus.write_enable), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check($sformatf("bp%0d_we", i), int'(bus.write_enable), 0);
      check($sformatf("bp%0d_dout", i), int'(bus.data_out), 0);
    end
    bus.fifo_out_full = 1'b0;
    #1;
    check("bp_we", int'(bus.write_enable), 1);
    check("bp_mask", int'(bus.data_out), 8'hFF);
    @(negedge clk); #1;
    check("bp_single_we", int'(bus.write_enable), 0);

    // Reset in S_CALC drops the pixel; count restarts so frame_done lands on the 8th later write
    bus.bg_din        = 8'd0;
    bus.fr_din        = 8'd255;
    bus.bg_fifo_empty = 1'b0;
    bus.fr_fifo_empty = 1'b0;
    #1;
    check("rc_rd", int'({bus.bg_read_enable, bus.fr_read_enable}), 3);
    @(negedge clk);
    bus.bg_fifo_empty = 1'b1;
    bus.fr_fifo_empty = 1'b1;
    reset = 1'b1;
    @(negedge clk); #1;
    check("rc_we0", int'(bus.write_enable), 0);
    check("rc_dout0", int'(bus.data_out), 0);
    reset = 1'b0;
    @(negedge clk); #1;
    check("rc_we1", int'(bus.write_enable), 0);
    check("rc_fd", int'(bus.frame_done), 0);
    for (int i = 0; i < 8; i++) run_pixel(vecs[i].bg, vecs[i].fr, vecs[i].mask, vecs[i].fd,
                                          $sformatf("post_rst%0d", i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
